// File: rtl/conv_pkg.sv
// Shared constants, bank selects and handshake FSM states for the CONV memory host.
package conv_pkg;
    localparam int DW        = 20;
    localparam int AW        = 12;
    localparam int IMG_DEPTH = 4096;
    localparam int L0_DEPTH  = 4096;
    localparam int L1_DEPTH  = 1024;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } host_state_e;
endpackage

// File: rtl/conv_bank_ram.sv
// Word RAM: one synchronous write port, one combinational read port, one registered read port.
// Any address at or beyond DEPTH drops the write and reads back as zero.
module conv_bank_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 20,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] araddr_i,
    output logic [DW-1:0] ardata_o,
    input  logic [AW-1:0] rraddr_i,
    output logic [DW-1:0] rrdata_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;
    logic          w_ok, a_ok, r_ok;

    assign w_ok = 32'(waddr_i)  < DEPTH;
    assign a_ok = 32'(araddr_i) < DEPTH;
    assign r_ok = 32'(rraddr_i) < DEPTH;

    always_ff @(posedge clk) begin
        if (we_i && w_ok)
            mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end

    assign ardata_o = a_ok ? mem_q[araddr_i[IW-1:0]] : '0;
    assign rdata_d  = r_ok ? mem_q[rraddr_i[IW-1:0]] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rrdata_o = rdata_q;
endmodule

// File: rtl/conv_mem_host.sv
// Memory-side responder for the CONV engine: image/L0/L1 banks, host load and dump ports,
// and the ready/busy start handshake. Define CONV_HOST_ERRCHK_EN to build the sticky err checker.
module conv_mem_host
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          done,
    output logic          err,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    input  logic          rd_sel,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    host_state_e state_q, state_d;
    logic        rd_sel_q;
    logic        host_win, sel_l0, sel_l1;
    logic [DW-1:0] l0_rd, l1_rd, l0_dump, l1_dump, img_dump_unused;

    assign host_win = (state_q == S_IDLE) || (state_q == S_DONE);
    assign sel_l0   = (csel == CSEL_L0);
    assign sel_l1   = (csel == CSEL_L1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel;
        end
    end

    // RUN is only entered with busy high, so busy low there is the 1->0 edge.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE:      if (start) state_d = S_ARM;
            S_ARM: begin
                ready   = 1'b1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (busy) state_d = S_RUN;
            S_RUN:       if (!busy) state_d = S_DONE;
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_ARM;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    conv_bank_ram #(.DEPTH(IMG_DEPTH), .DW(DW), .AW(AW)) u_img (
        .clk      (clk),
        .reset    (reset),
        .we_i     (ld_valid && host_win),
        .waddr_i  (ld_addr),
        .wdata_i  (ld_data),
        .araddr_i (iaddr),
        .ardata_o (idata),
        .rraddr_i ('0),
        .rrdata_o (img_dump_unused)
    );

    conv_bank_ram #(.DEPTH(L0_DEPTH), .DW(DW), .AW(AW)) u_l0 (
        .clk      (clk),
        .reset    (reset),
        .we_i     (cwr && sel_l0),
        .waddr_i  (caddr_wr),
        .wdata_i  (cdata_wr),
        .araddr_i (caddr_rd),
        .ardata_o (l0_rd),
        .rraddr_i (rd_addr),
        .rrdata_o (l0_dump)
    );

    conv_bank_ram #(.DEPTH(L1_DEPTH), .DW(DW), .AW(AW)) u_l1 (
        .clk      (clk),
        .reset    (reset),
        .we_i     (cwr && sel_l1),
        .waddr_i  (caddr_wr),
        .wdata_i  (cdata_wr),
        .araddr_i (caddr_rd),
        .ardata_o (l1_rd),
        .rraddr_i (rd_addr),
        .rrdata_o (l1_dump)
    );

    assign cdata_rd = !crd   ? '0    :
                      sel_l0 ? l0_rd :
                      sel_l1 ? l1_rd : '0;

    // Both banks register their dump word; the delayed select picks the matching one.
    assign rd_data = rd_sel_q ? l1_dump : l0_dump;

`ifdef CONV_HOST_ERRCHK_EN
    logic err_q, err_d;
    logic bad_wr;

    assign bad_wr = cwr && (!(sel_l0 || sel_l1) ||
                            (sel_l0 && 32'(caddr_wr) >= L0_DEPTH) ||
                            (sel_l1 && 32'(caddr_wr) >= L1_DEPTH));

    always_comb begin
        err_d = err_q;
        if (bad_wr || (crd && !(sel_l0 || sel_l1)) || (cwr && crd) ||
            (ld_valid && !host_win) || (busy && host_win))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
